// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment scan controller.
package seg_pkg;

    localparam int          NDIG       = 8;
    localparam int          IDX_W      = 3;
    localparam int          DUTY_W     = 4;
    localparam logic [4:0]  BLANK_CODE = 5'h10;

    typedef logic [4:0]       digit_code_t;
    typedef logic [NDIG-1:0]  an_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Active-low one-cold anode pattern for the given digit
    function automatic an_t anode_for(input idx_t idx);
        return ~(an_t'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression mask: digit i is masked when it and every digit above
// it hold a zero nibble. Digit 0 is never masked so an all-zero value shows "0".
module seg_lz_mask
    import seg_pkg::*;
(
    input  logic [4*NDIG-1:0] data,
    input  logic              lz_en,
    output logic [NDIG-1:0]   mask
);

    assign mask[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NDIG; gi++) begin : g_mask
            assign mask[gi] = lz_en && (data[4*NDIG-1:4*gi] == '0);
        end
    endgenerate

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller: slot divider, frame-synchronous double-buffered load port,
// per-digit blanking, leading-zero suppression and 16-level PWM brightness.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV_W = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [4*NDIG-1:0]  ld_data,
    input  logic [NDIG-1:0]    ld_blank,
    input  logic               lz_en,
    input  logic [DUTY_W-1:0]  bright,
    output digit_code_t        digit_code,
    output an_t                an,
    output logic               frame_tick
);

    logic [DIV_W-1:0]   divcnt_reg, divcnt_next;
    idx_t               idx_reg, idx_next;
    logic               pend_full_reg, pend_full_next;
    logic [4*NDIG-1:0]  pend_data_reg, pend_data_next;
    logic [NDIG-1:0]    pend_blank_reg, pend_blank_next;
    logic [4*NDIG-1:0]  active_data_reg, active_data_next;
    logic [NDIG-1:0]    active_blank_reg, active_blank_next;
    an_t                an_reg, an_next;
    digit_code_t        code_reg, code_next;
    logic               tick_reg, tick_next;

    logic [NDIG-1:0]    lz_mask;
    logic               slot_end;
    logic               frame_end;
    logic               accept;
    logic               dark;
    logic               lit;
    logic               first_cycle;
    logic [DUTY_W-1:0]  duty_lvl;
    logic [3:0]         cur_nibble;

    seg_lz_mask u_lz_mask (
        .data  (active_data_reg),
        .lz_en (lz_en),
        .mask  (lz_mask)
    );

    assign slot_end    = &divcnt_reg;
    assign frame_end   = slot_end && (idx_reg == idx_t'(NDIG-1));
    assign accept      = ld_valid && !pend_full_reg;
    assign first_cycle = (divcnt_reg == '0);
    assign duty_lvl    = divcnt_reg[DIV_W-1 -: DUTY_W];
    assign cur_nibble  = active_data_reg[4*idx_reg +: 4];
    assign dark        = active_blank_reg[idx_reg] | lz_mask[idx_reg];
    // Slot's first cycle is always dark so the previous digit cannot ghost
    assign lit         = !dark && !first_cycle && (duty_lvl <= bright);

    always_comb begin
        divcnt_next       = divcnt_reg + 1'b1;
        idx_next          = idx_reg;
        pend_full_next    = pend_full_reg;
        pend_data_next    = pend_data_reg;
        pend_blank_next   = pend_blank_reg;
        active_data_next  = active_data_reg;
        active_blank_next = active_blank_reg;

        if (slot_end) begin
            idx_next = (idx_reg == idx_t'(NDIG-1)) ? '0 : idx_reg + 1'b1;
        end

        // Pending is full whenever a commit is possible, so accept and commit never collide
        if (frame_end && pend_full_reg) begin
            active_data_next  = pend_data_reg;
            active_blank_next = pend_blank_reg;
            pend_full_next    = 1'b0;
        end else if (accept) begin
            pend_data_next  = ld_data;
            pend_blank_next = ld_blank;
            pend_full_next  = 1'b1;
        end
    end

    always_comb begin
        code_next = dark ? BLANK_CODE : {1'b0, cur_nibble};
        an_next   = lit ? anode_for(idx_reg) : '1;
        tick_next = frame_end;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divcnt_reg       <= '0;
            idx_reg          <= '0;
            pend_full_reg    <= 1'b0;
            pend_data_reg    <= '0;
            pend_blank_reg   <= '0;
            active_data_reg  <= '0;
            active_blank_reg <= '1;
            an_reg           <= '1;
            code_reg         <= BLANK_CODE;
            tick_reg         <= 1'b0;
        end else begin
            divcnt_reg       <= divcnt_next;
            idx_reg          <= idx_next;
            pend_full_reg    <= pend_full_next;
            pend_data_reg    <= pend_data_next;
            pend_blank_reg   <= pend_blank_next;
            active_data_reg  <= active_data_next;
            active_blank_reg <= active_blank_next;
            an_reg           <= an_next;
            code_reg         <= code_next;
            tick_reg         <= tick_next;
        end
    end

    assign ld_ready   = !pend_full_reg;
    assign an         = an_reg;
    assign digit_code = code_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized loads, checked every
// cycle against a time-based model of the scan, load and brightness rules.
module tb_seg_scan_ctrl;

    localparam int DIV_W = 6;
    localparam int SLOT  = 64;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic [7:0]  ld_blank;
    logic        lz_en;
    logic [3:0]  bright;
    logic [4:0]  digit_code;
    logic [7:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    bit          m_pend;
    logic [31:0] m_pdata, m_adata;
    logic [7:0]  m_pblank, m_ablank;
    int          pos;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_blank   (ld_blank),
        .lz_en      (lz_en),
        .bright     (bright),
        .digit_code (digit_code),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h pos=%0d t=%0t", tag, got, exp, pos, $time);
        end
    endtask

    // One clock: predict outputs from the time since reset, advance the model, compare
    task automatic step();
        int          p, slot, di, top;
        bit          dark, lit, e_tick, acc;
        logic [7:0]  e_an;
        logic [4:0]  e_code;
        check_eq("ld_ready", {31'd0, ld_ready}, {31'd0, !m_pend});
        p    = pos % FRAME;
        slot = p % SLOT;
        di   = p / SLOT;
        top  = 0;
        for (int i = 0; i < 8; i++)
            if (m_adata[4*i +: 4] != 4'd0) top = i;
        dark   = m_ablank[di] || (lz_en && di > top);
        lit    = !dark && slot != 0 && (slot / (SLOT / 16)) <= int'(bright);
        e_an   = lit ? (8'hFF ^ (8'd1 << di)) : 8'hFF;
        e_code = dark ? 5'h10 : {1'b0, m_adata[4*di +: 4]};
        e_tick = (p == FRAME - 1);
        acc    = ld_valid && !m_pend;
        if (e_tick && m_pend) begin
            m_adata  = m_pdata;
            m_ablank = m_pblank;
            m_pend   = 1'b0;
        end else if (acc) begin
            m_pdata  = ld_data;
            m_pblank = ld_blank;
            m_pend   = 1'b1;
            $display("LOAD data=%08h blank=%02h at frame pos %0d", ld_data, ld_blank, p);
        end
        @(posedge clk);
        #1;
        pos++;
        if (acc) ld_valid = 1'b0;
        check_eq("an", {24'd0, an}, {24'd0, e_an});
        check_eq("digit_code", {27'd0, digit_code}, {27'd0, e_code});
        check_eq("frame_tick", {31'd0, frame_tick}, {31'd0, e_tick});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] b);
        ld_data  = d;
        ld_blank = b;
        ld_valid = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_an", {24'd0, an}, 32'hFF);
        check_eq("rst_code", {27'd0, digit_code}, 32'h10);
        check_eq("rst_tick", {31'd0, frame_tick}, 32'd0);
        check_eq("rst_ready", {31'd0, ld_ready}, 32'd1);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        m_pend   = 1'b0;
        m_adata  = '0;
        m_ablank = 8'hFF;
        m_pdata  = '0;
        m_pblank = '0;
        pos      = 0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check_reset_outputs();
        end
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_blank = '0;
        lz_en    = 1'b0;
        bright   = 4'hF;
        @(posedge clk);
        #1;
        do_reset(2);

        // Dark with no load committed
        run(FRAME + 10);

        // Basic load, full brightness
        offer(32'h12345678, 8'h00);
        run(2 * FRAME);

        // Second offer while the first is still pending
        offer(32'hAAAAAAAA, 8'h00);
        run(100);
        offer(32'h55555555, 8'h00);
        run(3 * FRAME);

        // Leading-zero suppression
        lz_en = 1'b1;
        offer(32'h000000A0, 8'h00);
        run(2 * FRAME);
        offer(32'h00000000, 8'h00);
        run(2 * FRAME);

        // Brightness levels
        lz_en = 1'b0;
        offer(32'h12345678, 8'h00);
        run(FRAME);
        bright = 4'd3;
        run(FRAME);
        bright = 4'd0;
        run(FRAME);

        // Per-digit blanking, then reset while a load is pending
        bright = 4'hF;
        offer(32'h87654321, 8'h81);
        run(2 * FRAME);
        offer(32'h11111111, 8'h00);
        run(50);
        do_reset(3);
        run(FRAME + 5);

        // Randomized loads, brightness and suppression
        for (int n = 0; n < 24; n++) begin
            logic [31:0] d;
            logic [7:0]  b;
            for (int k = 0; k < 2 * FRAME && ld_valid; k++) step();
            check_eq("accept_timeout", {31'd0, ld_valid}, 32'd0);
            d = $urandom >> $urandom_range(0, 31);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            bright = 4'($urandom_range(0, 15));
            lz_en  = 1'($urandom_range(0, 1));
            offer(d, b);
            run($urandom_range(40, 700));
            if (n == 12) begin
                do_reset(1);
                ld_valid = 1'b0;
            end
        end
        run(FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
